// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU constants for the ALU arbiter slice.
// Holds the data and control-code widths and the ALU control-code encodings.
package alu_pkg;

    localparam int unsigned AluDataW = 32;
    localparam int unsigned AluCtrlW = 3;

    typedef enum logic [AluCtrlW-1:0] {
        AluNop = 3'b000,
        AluAdd = 3'b001,
        AluSub = 3'b010,
        AluXor = 3'b011,
        AluOr  = 3'b100,
        AluAnd = 3'b101
    } alu_ctrl_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side and response-side handshake bundle of alu_arbiter.
//   req_valid_i / req_ready_o      per-requester valid/ready
//   req_data1_i / req_data2_i      packed operands, requester k at [32k+31:32k]
//   req_ctrl_i                     packed 3-bit ALU control codes
//   req_lock_i                     grant-lock request (only with ALU_ARB_LOCK_EN)
//   resp_valid_o / resp_ready_i    response register handshake
//   resp_data_o / resp_id_o        registered result and owning requester index
// Modport slave is the arbiter; master is the requester/consumer side.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
);

    logic [NUM_REQ-1:0]          req_valid_i;
    logic [NUM_REQ-1:0]          req_ready_o;
    logic [NUM_REQ*AluDataW-1:0] req_data1_i;
    logic [NUM_REQ*AluDataW-1:0] req_data2_i;
    logic [NUM_REQ*AluCtrlW-1:0] req_ctrl_i;
`ifdef ALU_ARB_LOCK_EN
    logic [NUM_REQ-1:0]          req_lock_i;
`endif
    logic                        resp_valid_o;
    logic                        resp_ready_i;
    logic [AluDataW-1:0]         resp_data_o;
    logic [ID_W-1:0]             resp_id_o;

    modport slave (
        input  req_valid_i, req_data1_i, req_data2_i, req_ctrl_i,
`ifdef ALU_ARB_LOCK_EN
        input  req_lock_i,
`endif
        input  resp_ready_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_id_o
    );

    modport master (
        output req_valid_i, req_data1_i, req_data2_i, req_ctrl_i,
`ifdef ALU_ARB_LOCK_EN
        output req_lock_i,
`endif
        output resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_id_o
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req_i        request vector
//   ptr_i        highest-priority requester index
//   en_i         grant enable (no grant while low)
//   gnt_o        one-hot grant
//   gnt_idx_o    index of the granted requester
//   gnt_valid_o  a grant exists
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               gnt_valid_o
);

    int unsigned pos;
    logic        found;

    // Scan upward from ptr_i with wrap; the first hit wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        pos       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = (32'(ptr_i) + i) % NUM_REQ;
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (en_i && !found && (pos == j) && req_i[j]) begin
                    gnt_o[j]  = 1'b1;
                    gnt_idx_o = ID_W'(j);
                    found     = 1'b1;
                end
            end
        end
        gnt_valid_o = found;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one integer ALU between NUM_REQ requesters.
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   arb_if           requester and response handshakes (alu_arbiter_if.slave)
//   alu_data1_o/alu_data2_o/alu_ctrl_o   granted operands and code to the ALU
//   alu_result_i     combinational ALU result, captured into the response register
// Optional feature macro ALU_ARB_LOCK_EN: a requester can hold the grant across
// operations with req_lock_i.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    alu_arbiter_if.slave        arb_if,
    output logic [AluDataW-1:0] alu_data1_o,
    output logic [AluDataW-1:0] alu_data2_o,
    output logic [AluCtrlW-1:0] alu_ctrl_o,
    input  logic [AluDataW-1:0] alu_result_i
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e               state_q, state_d;
    logic [AluDataW-1:0]  resp_data_q, resp_data_d;
    logic [ID_W-1:0]      resp_id_q, resp_id_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                 can_accept;
    logic                 transfer;
    logic                 ptr_frozen;
    logic [NUM_REQ-1:0]   req_eff;
    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_valid;

    assign can_accept = (state_q == StEmpty) || arb_if.resp_ready_i;
    assign transfer   = gnt_valid && can_accept;

`ifdef ALU_ARB_LOCK_EN
    logic               lock_q, lock_d;
    logic [ID_W-1:0]    lock_id_q, lock_id_d;
    logic [NUM_REQ-1:0] lock_mask;

    assign lock_mask  = lock_q ? (NUM_REQ'(1) << lock_id_q) : '1;
    assign req_eff    = arb_if.req_valid_i & lock_mask;
    assign ptr_frozen = lock_q;

    // A holder that drops valid while we could accept gives the lock up.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (transfer) begin
            lock_d    = |(arb_if.req_lock_i & gnt);
            lock_id_d = gnt_idx;
        end else if (lock_q && can_accept && !(|(arb_if.req_valid_i & lock_mask))) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    assign req_eff    = arb_if.req_valid_i;
    assign ptr_frozen = 1'b0;
`endif

    // Grants are suppressed while reset is held so no ready escapes.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i       (req_eff),
        .ptr_i       (rr_ptr_q),
        .en_i        (rst_n_i),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign arb_if.req_ready_o = can_accept ? gnt : '0;

    always_comb begin
        alu_data1_o = '0;
        alu_data2_o = '0;
        alu_ctrl_o  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                alu_data1_o = arb_if.req_data1_i[k*AluDataW +: AluDataW];
                alu_data2_o = arb_if.req_data2_i[k*AluDataW +: AluDataW];
                alu_ctrl_o  = arb_if.req_ctrl_i[k*AluCtrlW +: AluCtrlW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (transfer) begin
            state_d     = StFull;
            resp_data_d = alu_result_i;
            resp_id_d   = gnt_idx;
            if (!ptr_frozen) begin
                rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
        end else if (arb_if.resp_ready_i) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StEmpty;
            resp_data_q <= '0;
            resp_id_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign arb_if.resp_valid_o = (state_q == StFull);
    assign arb_if.resp_data_o  = resp_data_q;
    assign arb_if.resp_id_o    = resp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with three requesters.
// A reference model tracks arbitration and the response register; expected
// results are queued on each modelled transfer and compared while the DUT
// holds them. Directed phases cover reset, single ops, round-robin order,
// backpressure, mid-operation reset and (with ALU_ARB_LOCK_EN) grant locking.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(NR), .ID_W(2)) arb_if ();

    logic [31:0] alu_d1, alu_d2, alu_res;
    logic [2:0]  alu_ctrl;

    alu_arbiter #(
        .NUM_REQ (NR),
        .ID_W    (2)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .arb_if       (arb_if),
        .alu_data1_o  (alu_d1),
        .alu_data2_o  (alu_d2),
        .alu_ctrl_o   (alu_ctrl),
        .alu_result_i (alu_res)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
        case (op)
            AluAdd:  return x + y;
            AluSub:  return x - y;
            AluXor:  return x ^ y;
            AluOr:   return x | y;
            AluAnd:  return x & y;
            default: return x;
        endcase
    endfunction

    assign alu_res = alu_f(alu_ctrl, alu_d1, alu_d2);

    // Per-requester stimulus, packed onto the interface.
    bit          v [NR];
    logic [2:0]  c [NR];
    logic [31:0] a [NR];
    logic [31:0] b [NR];
    bit          lk[NR];

    always_comb begin
        arb_if.req_valid_i = '0;
        arb_if.req_ctrl_i  = '0;
        arb_if.req_data1_i = '0;
        arb_if.req_data2_i = '0;
`ifdef ALU_ARB_LOCK_EN
        arb_if.req_lock_i  = '0;
`endif
        for (int k = 0; k < NR; k++) begin
            arb_if.req_valid_i[k]         = v[k];
            arb_if.req_ctrl_i[k*3 +: 3]   = c[k];
            arb_if.req_data1_i[k*32 +: 32] = a[k];
            arb_if.req_data2_i[k*32 +: 32] = b[k];
`ifdef ALU_ARB_LOCK_EN
            arb_if.req_lock_i[k]          = lk[k];
`endif
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          m_ptr, m_lock_id, g;
    bit          m_full, m_lock, found, acc;
    bit          acc_vec[NR];
    logic [NR-1:0] exp_rdy;

    // Reference model, evaluated between edges with inputs stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", 64'(arb_if.req_ready_o), 64'(0));
            chk("rst_resp_valid", 64'(arb_if.resp_valid_o), 64'(0));
            m_ptr = 0; m_full = 0; m_lock = 0; m_lock_id = 0;
            exp_q.delete();
            for (int k = 0; k < NR; k++) acc_vec[k] = 0;
        end else begin
            acc   = !m_full || arb_if.resp_ready_i;
            found = 0;
            g     = 0;
            for (int i = 0; i < NR; i++) begin
                int k;
                k = (m_ptr + i) % NR;
                if (!found && v[k] && (!m_lock || k == m_lock_id)) begin
                    found = 1;
                    g     = k;
                end
            end
            for (int k = 0; k < NR; k++) exp_rdy[k] = found && acc && (k == g);
            chk("ready", 64'(arb_if.req_ready_o), 64'(exp_rdy));
            chk("resp_valid", 64'(arb_if.resp_valid_o), 64'(m_full));
            if (m_full) begin
                chk("resp_data", 64'(arb_if.resp_data_o), 64'(exp_q[0].data));
                chk("resp_id", 64'(arb_if.resp_id_o), 64'(exp_q[0].id));
            end
            chk("alu_data1", 64'(alu_d1), found ? 64'(a[g]) : 64'(0));
            chk("alu_data2", 64'(alu_d2), found ? 64'(b[g]) : 64'(0));
            chk("alu_ctrl", 64'(alu_ctrl), found ? 64'(c[g]) : 64'(0));

            if (m_full && arb_if.resp_ready_i) begin
                void'(exp_q.pop_front());
                m_full = 0;
            end
            for (int k = 0; k < NR; k++) acc_vec[k] = 0;
            if (found && acc) begin
                exp_q.push_back('{id: g, data: alu_f(c[g], a[g], b[g])});
                m_full     = 1;
                acc_vec[g] = 1;
                if (!m_lock) m_ptr = (g + 1) % NR;
`ifdef ALU_ARB_LOCK_EN
                m_lock    = lk[g];
                m_lock_id = g;
            end else if (m_lock && acc && !v[m_lock_id]) begin
                m_lock = 0;
`endif
            end
        end
    end

    task automatic set_op(input int k, input bit vv, input logic [2:0] cc,
                          input logic [31:0] aa, input logic [31:0] bb);
        v[k] = vv; c[k] = cc; a[k] = aa; b[k] = bb; lk[k] = 0;
    endtask

    task automatic clear_all();
        for (int k = 0; k < NR; k++) v[k] = 0;
    endtask

    // One op from requester k in isolation; checks the registered result.
    task automatic single_op(input string tag, input int k, input logic [2:0] cc,
                             input logic [31:0] aa, input logic [31:0] bb,
                             input logic [31:0] exp_data);
        @(posedge clk); #1;
        set_op(k, 1, cc, aa, bb);
        @(posedge clk); #1;
        v[k] = 0;
        @(negedge clk);
        chk({tag, "_data"}, 64'(arb_if.resp_data_o), 64'(exp_data));
        chk({tag, "_id"}, 64'(arb_if.resp_id_o), 64'(k));
    endtask

    initial begin
        rst_n = 1'b0;
        arb_if.resp_ready_i = 1'b1;
        set_op(0, 1, AluXor, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        set_op(1, 1, AluOr,  32'h0000_0011, 32'h0000_1100);
        set_op(2, 1, AluAnd, 32'hFFFF_0000, 32'h1234_5678);

        // Reset with every requester valid; requester 0 wins first.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("rst_first_gnt", 64'(arb_if.req_ready_o), 64'(3'b001));
        @(posedge clk); #1;
        clear_all();
        @(negedge clk);
        chk("rst_first_id", 64'(arb_if.resp_id_o), 64'(0));
        chk("rst_first_data", 64'(arb_if.resp_data_o), 64'(32'hFF00_FF00));

        single_op("add_ovf", 1, AluAdd, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        single_op("sub_wrap", 1, AluSub, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        single_op("bad_ctrl", 2, 3'b111, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678);

        // Round-robin with all valid; the pointer is back at 0 here.
        @(posedge clk); #1;
        set_op(0, 1, AluXor, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        set_op(1, 1, AluOr,  32'h0000_0011, 32'h0000_1100);
        set_op(2, 1, AluAnd, 32'hFFFF_0000, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rr_id", 64'(arb_if.resp_id_o), 64'(i % 3));
        end
        @(posedge clk); #1;
        clear_all();

        // Backpressure: pointer is 2, so requester 0 fills first, then stalls.
        @(posedge clk); #1;
        v[0] = 1; v[1] = 1;
        @(posedge clk); #1;
        arb_if.resp_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", 64'(arb_if.req_ready_o), 64'(0));
            chk("bp_hold", 64'(arb_if.resp_data_o), 64'(32'hFF00_FF00));
        end
        @(posedge clk); #1;
        arb_if.resp_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_refill", 64'(arb_if.req_ready_o), 64'(3'b010));
        @(posedge clk); #1;
        clear_all();
        @(negedge clk);
        chk("bp_next_id", 64'(arb_if.resp_id_o), 64'(1));
        chk("bp_next_data", 64'(arb_if.resp_data_o), 64'(32'h0000_1111));

        // Reset while a response is pending.
        @(posedge clk); #1;
        v[0] = 1;
        arb_if.resp_ready_i = 1'b0;
        @(posedge clk); #1;
        v[0] = 0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(arb_if.resp_valid_o), 64'(0));
        chk("arst_data", 64'(arb_if.resp_data_o), 64'(0));
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        arb_if.resp_ready_i = 1'b1;

`ifdef ALU_ARB_LOCK_EN
        // Requester 0 locks for three ops while requester 1 waits.
        @(posedge clk); #1;
        set_op(0, 1, AluAdd, 32'h0000_0010, 32'h0000_0001);
        set_op(1, 1, AluSub, 32'h0000_0010, 32'h0000_0001);
        lk[0] = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) lk[0] = 0;
            if (i == 2) v[0] = 0;
            @(negedge clk);
            chk("lock_id", 64'(arb_if.resp_id_o), (i < 3) ? 64'(0) : 64'(1));
        end
        @(posedge clk); #1;
        clear_all();
`endif

        // Random traffic; fields only change once the request is taken.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NR; k++) begin
                if (!v[k] || acc_vec[k]) begin
                    v[k]  = ($urandom_range(0, 3) != 0);
                    c[k]  = 3'($urandom_range(0, 7));
                    a[k]  = $urandom;
                    b[k]  = $urandom;
                    lk[k] = 1'($urandom_range(0, 1));
                end
            end
            arb_if.resp_ready_i = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        clear_all();
        arb_if.resp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single integer ALU between up to four requesters, e.g. the EX-stage operand path and the branch/address-generation unit, with valid/ready handshakes on both sides. It grants one requester per cycle by round-robin and drives the granted operands and control code onto the ALU. The combinational ALU result is captured into a one-entry response register tagged with the requester index. The block sits between the EX-stage operand muxes and the ALU, and its response register feeds EX_MEM-side consumers.

## Interface
- NUM_REQ, 2, number of requesters; legal values are 2 to 4.
- ID_W, 2, width of the requester index; must satisfy 2**ID_W >= NUM_REQ.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester operation valid.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit is high.
- req_data1_i  in  NUM_REQ*32  operand 1 per requester, packed with requester k at bits [32k+31:32k].
- req_data2_i  in  NUM_REQ*32  operand 2 per requester, packed the same way.
- req_ctrl_i  in  NUM_REQ*3  ALU control code per requester (ADD 001, SUB 010, XOR 011, OR 100, AND 101).
- req_lock_i  in  NUM_REQ  request to keep the grant for the next operation; present only with ALU_ARB_LOCK_EN.
- alu_data1_o  out  32  to ALU data1.
- alu_data2_o  out  32  to ALU data2.
- alu_ctrl_o  out  3  to ALU control.
- alu_result_i  in  32  from ALU result.
- resp_valid_o  out  1  response register holds a result.
- resp_ready_i  in  1  consumer accepts the response.
- resp_data_o  out  32  registered ALU result.
- resp_id_o  out  ID_W  index of the requester that owns resp_data_o.

## Operation
- Output-register state machine:
  - EMPTY: resp_valid_o=0.
  - FULL: resp_valid_o=1.
- can_accept = !resp_valid_o | resp_ready_i. Drain and refill may happen in the same cycle.
- Grant selection:
  - Grant is combinational: the first requester with req_valid_i high, searching upward from rr_ptr and wrapping NUM_REQ-1 → 0.
  - req_ready_o[g] = can_accept & req_valid_i[g]. All other ready bits are 0.
- Transfer: a transfer to requester g happens when req_valid_i[g] & req_ready_o[g]. On the transfer edge:
  - resp_data_o ← alu_result_i and resp_id_o ← g.
  - The state machine goes to FULL.
  - rr_ptr ← (g+1) mod NUM_REQ.
- Response drain:
  - resp_valid_o & resp_ready_i with no new transfer → EMPTY.
  - Drain and transfer in the same cycle → stays FULL with the new data.
- ALU drive:
  - While a grant exists, alu_*_o carry the granted requester's fields.
  - With no grant, alu_data1_o=0, alu_data2_o=0 and alu_ctrl_o=3'b000.
- Control codes pass through unchanged. Undefined codes give the ALU's default (data1 passthrough).
- Arithmetic is 32-bit with wrap-around and no flags, as the ALU itself defines.
- A valid request with no grant holds its request; its fields must stay stable until accepted. The bench checks this.
- rr_ptr is not updated on a stall (resp_valid_o=1 & resp_ready_i=0), so arbitration is unchanged when the stall ends.

## Timing
- Reset (asynchronous, rst_n_i=0) sets:
  - resp_valid_o=0, resp_data_o=0, resp_id_o=0, rr_ptr=0.
  - Lock state cleared.
  - req_ready_o forced to all zeros while rst_n_i is low.
- Latency: a request accepted in cycle n shows resp_valid_o=1 in cycle n+1.
- Throughput: one operation per cycle while resp_ready_i stays high.
- Reset asserted mid-operation: the pending response is dropped and no ready is issued until the cycle after deassertion.
- A requester holding valid is granted within NUM_REQ accepting cycles. This is the starvation bound.

## Configuration
- Macro: ALU_ARB_LOCK_EN.
- Defined:
  - req_lock_i exists.
  - On a transfer with req_lock_i[g]=1, the lock is set to g. While locked, only g can be granted and rr_ptr is frozen.
  - The lock is released on g's first transfer with req_lock_i[g]=0, or when req_valid_i[g]=0 while can_accept=1.
- Undefined: the port is absent and arbitration is pure round-robin.

## Structure
- Shared package alu_pkg holds:
  - The ALU control-code constants (ADD, SUB, XOR, OR, AND).
  - The control-code width of 3 and the data width of 32.
- One sub-module, rr_arbiter:
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and grant index.

## Test plan
- Reset:
  - Stimulus: rst_n_i low with every req_valid_i=1.
  - Response: req_ready_o=0 and resp_valid_o=0.
  - After release, requester 0 is granted first.
- Single op:
  - Stimulus: requester 1 sends ADD 0x7FFFFFFF+1.
  - Response: next cycle resp_data_o=0x80000000, resp_id_o=1.
  - Same check with SUB 0-1, which must give 0xFFFFFFFF.
- Round-robin:
  - Stimulus: NUM_REQ=3, all requesters valid, resp_ready_i=1.
  - Response: resp_id_o sequence 0,1,2,0 on consecutive cycles.
- Backpressure:
  - Stimulus: resp_ready_i=0 for 3 cycles with results pending.
  - Response: resp_data_o holds and req_ready_o stays 0.
  - On resp_ready_i=1, drain and refill happen in the same cycle with no bubble.
- Lock (ALU_ARB_LOCK_EN):
  - Stimulus: requester 0 issues 3 ops with lock=1,1,0 while requester 1 is valid.
  - Response: ids 0,0,0 then 1.
- Invalid ctrl:
  - Stimulus: ctrl 3'b111 with data1=0x12345678.
  - Response: resp_data_o=0x12345678.
